instruction_buffer: RTL and testbench
=====================================

// Module: instruction_buffer
// PURPOSE
// - In-order FIFO between instruction fetch/decode and dispatch. Accepts up to 4 decoded
//   instructions per cycle, holds them, presents up to 4 oldest to dispatch per cycle.
// - Advertises free slots (capped at 4) back to fetch as its per-cycle fetch width.
// - Flushes all contents on a taken jump from the branch unit.
// PARAMETERS
// - DEPTH  16  entries; power of two, >= 8
// - EW     30  entry width: {opcode4, rt4, ra4, rb4, a_dep1, a_own4, b_dep1, b_own4,
//              uses_rb1, is_ld_str1, is_fxu1, is_branch1}, MSB first in that order
// PORTS
// - clk            in   1      clock, all state updates on posedge
// - rst_n          in   1      synchronous, active-low reset
// - flush          in   1      taken jump (is_jump); discard all entries
// - enq_valid      in   1      fetch presents decoded group this cycle
// - enq_cnt        in   3      number of valid slots in group, 0..4, slot 0 oldest
// - enq_entry      in   4*EW   slot i at [i*EW +: EW]
// - num_fetch      out  3      registered min(4, free entries); fetch width next cycle
// - deq_entry      out  4*EW   entries head+0..head+3, slot 0 oldest
// - deq_valid      out  4      deq_valid[i] = (count > i)
// - deq_cnt        in   3      entries dispatch consumes this cycle, 0..4, from slot 0
// - count          out  $clog2(DEPTH)+1  current occupancy
// - err_overflow   out  1      sticky: enqueue exceeded advertised num_fetch
// - err_underflow  out  1      sticky: deq_cnt exceeded valid entries
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): head=tail=0, count=0, num_fetch=4, deq_valid=0,
//   err_overflow=err_underflow=0; storage contents don't-care. Reset overrides all inputs.
// - Pointers head/tail are $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
// - Enqueue (enq_valid & enq_cnt<=num_fetch): write slots 0..enq_cnt-1 to tail+0..tail+enq_cnt-1
//   (mod DEPTH); tail += enq_cnt. Slots >= enq_cnt ignored.
// - enq_valid & enq_cnt>num_fetch: whole group dropped, tail unchanged, err_overflow<=1.
// - Dequeue: eff = min(deq_cnt, count); head += eff. deq_cnt>count sets err_underflow.
// - Same cycle enq+deq: count_next = count + enq_accepted - eff; a full buffer (count=DEPTH)
//   with num_fetch=0 never accepts even if dequeuing (num_fetch is the registered value).
// - Latency: entry written at posedge N visible on deq_entry/deq_valid after posedge N;
//   no bypass from enq_entry to deq_entry in the same cycle (empty buffer -> deq_valid=0).
// - deq_entry/deq_valid are combinational reads of storage/count; deq_entry slots with
//   deq_valid=0 are don't-care.
// - num_fetch <= min(4, DEPTH - count_next) each posedge (registered, includes this
//   cycle's enq/deq).
// - Flush: head=tail=0, count=0, num_fetch=4 at that posedge; takes priority over enq and
//   deq in the same cycle (group presented with flush is discarded, no error flags set).
// - Error flags cleared only by reset. Owner/dep fields stored verbatim, never modified.
// STRUCTURE
// - Shared package ooo_pkg: EW, field offsets/widths, opcode constants, FETCH_W=4,
//   ib_entry_t packed struct matching field order above.
// - Sub-module ibuf_storage: DEPTH x EW register array, 4 write ports (index+enable),
//   4 async read ports; control (pointers, count, num_fetch, errors) in top.
// TESTING
// - Reset then enq 4 entries (opcodes 1,2,3,4) -> next cycle deq_valid=4'b1111, slot order
//   1,2,3,4; count=4; num_fetch=4.
// - Fill to 16 with no dequeue -> num_fetch steps 4,4,4,0 (after 4,8,12,16); enq_cnt=1 at
//   num_fetch=0 -> dropped, err_overflow=1, count stays 16.
// - Wrap: enq 4 / deq 4 for 6 cycles -> pointers wrap past 15, entry data order preserved,
//   count constant 4.
// - Simultaneous enq_cnt=3, deq_cnt=2 at count=5 -> count=6, head advances 2, new entries
//   appear after old ones.
// - Flush with enq_valid=1, enq_cnt=4, deq_cnt=2 at count=10 -> count=0, deq_valid=0,
//   num_fetch=4, no error flags.
// - deq_cnt=3 with count=1 -> head+1, count=0, err_underflow=1; rst_n=0 mid-fill clears all.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order front end: decoded entry layout,
// fetch group width and opcode encodings.
package ooo_pkg;

    localparam int FETCH_W = 4;

    localparam int OPC_W = 4;
    localparam int REG_W = 4;
    localparam int OWN_W = 4;

    // Entry field offsets, LSB-based, matching ib_entry_t below.
    localparam int IS_BRANCH_LSB = 0;
    localparam int IS_FXU_LSB    = 1;
    localparam int IS_LD_STR_LSB = 2;
    localparam int USES_RB_LSB   = 3;
    localparam int B_OWN_LSB     = 4;
    localparam int B_DEP_LSB     = B_OWN_LSB + OWN_W;
    localparam int A_OWN_LSB     = B_DEP_LSB + 1;
    localparam int A_DEP_LSB     = A_OWN_LSB + OWN_W;
    localparam int RB_LSB        = A_DEP_LSB + 1;
    localparam int RA_LSB        = RB_LSB + REG_W;
    localparam int RT_LSB        = RA_LSB + REG_W;
    localparam int OPCODE_LSB    = RT_LSB + REG_W;
    localparam int EW            = OPCODE_LSB + OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_LD  = 4'h8;
    localparam logic [OPC_W-1:0] OP_ST  = 4'h9;
    localparam logic [OPC_W-1:0] OP_BR  = 4'hc;
    localparam logic [OPC_W-1:0] OP_JMP = 4'hd;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic             a_dep;
        logic [OWN_W-1:0] a_own;
        logic             b_dep;
        logic [OWN_W-1:0] b_own;
        logic             uses_rb;
        logic             is_ld_str;
        logic             is_fxu;
        logic             is_branch;
    } ib_entry_t;

    // Fetch width advertised for a given number of free entries.
    function automatic logic [2:0] fetch_width(input logic [31:0] free);
        return (free >= 32'(FETCH_W)) ? 3'(FETCH_W) : free[2:0];
    endfunction

endpackage

// File: rtl/ibuf_storage.sv
// Instruction buffer entry array: FETCH_W indexed write ports and FETCH_W
// asynchronous read ports. Writers guarantee distinct indices per cycle.
module ibuf_storage
    import ooo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int EW_P  = ooo_pkg::EW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic [FETCH_W-1:0]            wr_en_i,
    input  logic [FETCH_W-1:0][AW-1:0]    wr_idx_i,
    input  logic [FETCH_W-1:0][EW_P-1:0]  wr_data_i,
    input  logic [FETCH_W-1:0][AW-1:0]    rd_idx_i,
    output logic [FETCH_W-1:0][EW_P-1:0]  rd_data_o
);

    logic [EW_P-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; validity is tracked by count in the
    // controller, so resetting it would only cost flops and reset fan-out.
    // NOTE: sequential state uses non-blocking assignment so every write
    // port sees the same pre-edge values.
    always_ff @(posedge clk) begin
        for (int p = 0; p < FETCH_W; p++) begin
            if (wr_en_i[p]) begin
                mem_q[wr_idx_i[p]] <= wr_data_i[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < FETCH_W; p++) begin
            rd_data_o[p] = mem_q[rd_idx_i[p]];
        end
    end

endmodule

// File: rtl/instruction_buffer.sv
// In-order instruction buffer between fetch/decode and dispatch: up to four
// entries in and out per cycle, advertised fetch width, flush on taken jump.
module instruction_buffer
    import ooo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int EW_P  = ooo_pkg::EW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        enq_valid,
    input  logic [2:0]                  enq_cnt,
    input  logic [FETCH_W*EW_P-1:0]     enq_entry,
    output logic [2:0]                  num_fetch,
    output logic [FETCH_W*EW_P-1:0]     deq_entry,
    output logic [FETCH_W-1:0]          deq_valid,
    input  logic [2:0]                  deq_cnt,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        err_overflow,
    output logic                        err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    num_fetch_q, num_fetch_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;

    logic          enq_ok;
    logic          enq_ovf;
    logic          deq_unf;
    logic [CW-1:0] enq_add;
    logic [CW-1:0] deq_req;
    logic [CW-1:0] deq_eff;
    logic [CW-1:0] free_d;

    logic [FETCH_W-1:0]           wr_en;
    logic [FETCH_W-1:0][AW-1:0]   wr_idx;
    logic [FETCH_W-1:0][EW_P-1:0] wr_data;
    logic [FETCH_W-1:0][AW-1:0]   rd_idx;
    logic [FETCH_W-1:0][EW_P-1:0] rd_data;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        enq_ok      = 1'b0;
        enq_ovf     = 1'b0;
        deq_unf     = 1'b0;
        enq_add     = '0;
        deq_req     = CW'(deq_cnt);
        deq_eff     = '0;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        err_ovf_d   = err_ovf_q;
        err_unf_d   = err_unf_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // The group is all-or-nothing against the width advertised last cycle.
            enq_ok  = enq_valid && (enq_cnt <= num_fetch_q);
            enq_ovf = enq_valid && (enq_cnt > num_fetch_q);
            enq_add = enq_ok ? CW'(enq_cnt) : '0;

            deq_unf = deq_req > count_q;
            deq_eff = deq_unf ? count_q : deq_req;

            head_d    = head_q + AW'(deq_eff);
            tail_d    = tail_q + AW'(enq_add);
            count_d   = count_q + enq_add - deq_eff;
            err_ovf_d = err_ovf_q | enq_ovf;
            err_unf_d = err_unf_q | deq_unf;
        end

        free_d      = CW'(DEPTH) - count_d;
        num_fetch_d = fetch_width(32'(free_d));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            num_fetch_q <= 3'(FETCH_W);
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            num_fetch_q <= num_fetch_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            wr_en[i]   = rst_n && enq_ok && (3'(i) < enq_cnt);
            wr_idx[i]  = tail_q + AW'(i);
            wr_data[i] = enq_entry[i*EW_P +: EW_P];
            rd_idx[i]  = head_q + AW'(i);
        end
    end

    ibuf_storage #(
        .DEPTH (DEPTH),
        .EW_P  (EW_P)
    ) u_storage (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    // Read side is purely combinational: no bypass from the enqueue group.
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            deq_entry[i*EW_P +: EW_P] = rd_data[i];
            deq_valid[i]              = count_q > CW'(i);
        end
    end

    assign count         = count_q;
    assign num_fetch     = num_fetch_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer: fill, overflow, wrap, mixed traffic,
// flush, underflow and reset, each entry tagged by a sequence number.
module tb_instruction_buffer;
    import ooo_pkg::*;

    localparam int DEPTH = 16;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               enq_valid;
    logic [2:0]         enq_cnt;
    logic [4*EW-1:0]    enq_entry;
    logic [2:0]         num_fetch;
    logic [4*EW-1:0]    deq_entry;
    logic [3:0]         deq_valid;
    logic [2:0]         deq_cnt;
    logic [4:0]         count;
    logic               err_overflow;
    logic               err_underflow;

    int checks = 0;
    int errors = 0;

    instruction_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .enq_valid     (enq_valid),
        .enq_cnt       (enq_cnt),
        .enq_entry     (enq_entry),
        .num_fetch     (num_fetch),
        .deq_entry     (deq_entry),
        .deq_valid     (deq_valid),
        .deq_cnt       (deq_cnt),
        .count         (count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct entry per sequence number; opcode carries the low nibble.
    function automatic logic [EW-1:0] ent(input int n);
        ib_entry_t e;
        e           = '0;
        e.opcode    = 4'(n);
        e.rt        = 4'(n >> 4);
        e.ra        = 4'(n * 3);
        e.rb        = 4'(~n);
        e.a_dep     = n[0];
        e.a_own     = 4'(n + 7);
        e.b_dep     = n[1];
        e.b_own     = 4'(n * 5);
        e.uses_rb   = 1'b1;
        e.is_ld_str = (e.opcode == OP_LD) || (e.opcode == OP_ST);
        e.is_fxu    = (e.opcode == OP_ADD) || (e.opcode == OP_SUB);
        e.is_branch = (e.opcode == OP_BR);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input int slot, input int n);
        chk(tag, 64'(deq_entry[slot*EW +: EW]), 64'(ent(n)));
    endtask

    task automatic cycle(input logic ev, input int ecnt, input int base,
                         input int dcnt, input logic fl);
        enq_valid = ev;
        enq_cnt   = 3'(ecnt);
        for (int i = 0; i < 4; i++) enq_entry[i*EW +: EW] = ent(base + i);
        deq_cnt   = 3'(dcnt);
        flush     = fl;
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        enq_cnt   = '0;
        deq_cnt   = '0;
        flush     = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_cnt   = '0;
        enq_entry = '0;
        deq_cnt   = '0;

        cycle(1'b1, 4, 200, 2, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(deq_valid), 64'h0);
        chk("rst_nf", 64'(num_fetch), 64'd4);
        chk("rst_ovf", 64'(err_overflow), 64'd0);
        chk("rst_unf", 64'(err_underflow), 64'd0);
        rst_n = 1'b1;

        // First group, opcodes 1..4, visible the cycle after it is written.
        cycle(1'b1, 4, 1, 0, 1'b0);
        chk("g1_valid", 64'(deq_valid), 64'hf);
        chk_slot("g1_s0", 0, 1);
        chk_slot("g1_s1", 1, 2);
        chk_slot("g1_s2", 2, 3);
        chk_slot("g1_s3", 3, 4);
        chk("g1_count", 64'(count), 64'd4);
        chk("g1_nf", 64'(num_fetch), 64'd4);

        // Fill to DEPTH without dequeue.
        cycle(1'b1, 4, 5, 0, 1'b0);
        chk("fill8_count", 64'(count), 64'd8);
        chk("fill8_nf", 64'(num_fetch), 64'd4);
        cycle(1'b1, 4, 9, 0, 1'b0);
        chk("fill12_count", 64'(count), 64'd12);
        chk("fill12_nf", 64'(num_fetch), 64'd4);
        cycle(1'b1, 4, 13, 0, 1'b0);
        chk("fill16_count", 64'(count), 64'd16);
        chk("fill16_nf", 64'(num_fetch), 64'd0);
        chk_slot("fill16_s0", 0, 1);

        // Enqueue while advertised width is zero is dropped and flagged.
        cycle(1'b1, 1, 99, 0, 1'b0);
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag", 64'(err_overflow), 64'd1);
        chk("ovf_unf", 64'(err_underflow), 64'd0);
        chk("ovf_nf", 64'(num_fetch), 64'd0);

        // Drain to 4 entries (13..16 remain, head=12, tail=0).
        cycle(1'b0, 0, 0, 4, 1'b0);
        chk("drain12_nf", 64'(num_fetch), 64'd4);
        cycle(1'b0, 0, 0, 4, 1'b0);
        cycle(1'b0, 0, 0, 4, 1'b0);
        chk("drain4_count", 64'(count), 64'd4);
        chk_slot("drain4_s0", 0, 13);
        chk_slot("drain4_s3", 3, 16);

        // Steady enq 4 / deq 4; both pointers wrap past DEPTH-1.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 4, 17 + 4*k, 4, 1'b0);
            chk("wrap_count", 64'(count), 64'd4);
            chk_slot("wrap_s0", 0, 17 + 4*k);
            chk_slot("wrap_s3", 3, 20 + 4*k);
        end

        // Count 5, then enq 3 / deq 2 together.
        cycle(1'b1, 1, 41, 0, 1'b0);
        chk("mix_pre_count", 64'(count), 64'd5);
        cycle(1'b1, 3, 42, 2, 1'b0);
        chk("mix_count", 64'(count), 64'd6);
        chk_slot("mix_s0", 0, 39);
        chk_slot("mix_s1", 1, 40);
        chk_slot("mix_s2", 2, 41);
        chk_slot("mix_s3", 3, 42);
        chk("mix_nf", 64'(num_fetch), 64'd4);

        // Flush at count 10 beats a concurrent enqueue and dequeue.
        cycle(1'b1, 4, 45, 0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd10);
        cycle(1'b1, 4, 50, 2, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(deq_valid), 64'h0);
        chk("flush_nf", 64'(num_fetch), 64'd4);
        chk("flush_unf", 64'(err_underflow), 64'd0);
        chk("flush_ovf_sticky", 64'(err_overflow), 64'd1);
        cycle(1'b1, 2, 60, 0, 1'b0);
        chk("post_flush_valid", 64'(deq_valid), 64'h3);
        chk_slot("post_flush_s0", 0, 60);
        chk_slot("post_flush_s1", 1, 61);

        // Over-dequeue consumes only what is there.
        cycle(1'b0, 0, 0, 1, 1'b0);
        chk("unf_pre_count", 64'(count), 64'd1);
        chk_slot("unf_pre_s0", 0, 61);
        cycle(1'b0, 0, 0, 3, 1'b0);
        chk("unf_count", 64'(count), 64'd0);
        chk("unf_flag", 64'(err_underflow), 64'd1);
        chk("unf_valid", 64'(deq_valid), 64'h0);
        cycle(1'b1, 1, 70, 0, 1'b0);
        chk("unf_head_s0", 0 == 0 ? 64'(deq_entry[0 +: EW]) : 64'd0, 64'(ent(70)));
        chk("unf_head_count", 64'(count), 64'd1);

        // Reset mid-fill clears everything, including sticky flags.
        cycle(1'b1, 4, 80, 0, 1'b0);
        chk("midfill_count", 64'(count), 64'd5);
        rst_n = 1'b0;
        cycle(1'b1, 4, 90, 1, 1'b0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(deq_valid), 64'h0);
        chk("mid_rst_nf", 64'(num_fetch), 64'd4);
        chk("mid_rst_ovf", 64'(err_overflow), 64'd0);
        chk("mid_rst_unf", 64'(err_underflow), 64'd0);
        rst_n = 1'b1;

        // Partial fetch width near full: 14 entries advertise 2, a group of 3 drops.
        cycle(1'b1, 4, 100, 0, 1'b0);
        cycle(1'b1, 4, 104, 0, 1'b0);
        cycle(1'b1, 4, 108, 0, 1'b0);
        cycle(1'b1, 2, 112, 0, 1'b0);
        chk("near_full_count", 64'(count), 64'd14);
        chk("near_full_nf", 64'(num_fetch), 64'd2);
        cycle(1'b1, 3, 120, 0, 1'b0);
        chk("near_full_drop_count", 64'(count), 64'd14);
        chk("near_full_drop_ovf", 64'(err_overflow), 64'd1);
        cycle(1'b1, 2, 130, 0, 1'b0);
        chk("full_count", 64'(count), 64'd16);
        chk("full_nf", 64'(num_fetch), 64'd0);
        chk_slot("full_s0", 0, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
